// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs long-latency unit.
// Optional operand forwarding of the in-flight write: WB_ARB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int RADDR_W      = 6,
  parameter int NREG         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb0_valid,
  input  logic [RADDR_W-1:0] wb0_rd,
  input  logic [XLEN-1:0]    wb0_data,
  input  logic               wb1_valid,
  output logic               wb1_ready,
  input  logic [RADDR_W-1:0] wb1_rd,
  input  logic [XLEN-1:0]    wb1_data,
  input  logic               sb_set,
  input  logic [RADDR_W-1:0] sb_rd,
  input  logic [RADDR_W-1:0] rs1,
  input  logic [RADDR_W-1:0] rs2,
  output logic               rs1_busy,
  output logic               rs2_busy,
  output logic               stall_pipe,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               rs1_fwd_valid,
  output logic               rs2_fwd_valid,
  output logic [XLEN-1:0]    rs1_fwd_data,
  output logic [XLEN-1:0]    rs2_fwd_data,
  output logic               err_waw
);

  localparam logic [RADDR_W:0] NREG_W = NREG[RADDR_W:0];
  localparam logic [3:0]       LIM    = STARVE_LIMIT[3:0];

  typedef enum logic {NORMAL, HOLD} state_t;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            stall_n;
  logic [NREG-1:0] sb;
  logic            wb0_eff, wb1_hs, wb1_eff, sb_eff;
  logic            fly1, fly2, sb1, sb2;

  function automatic logic legal(input logic [RADDR_W-1:0] a);
    legal = (a != '0) && ({1'b0, a} < NREG_W);
  endfunction

  function automatic logic sb_hit(
    input logic [NREG-1:0]    v,
    input logic [RADDR_W-1:0] a
  );
    sb_hit = 1'b0;
    for (int i = 1; i < NREG; i++)
      if (a == RADDR_W'(i)) sb_hit = v[i];
  endfunction

  assign wb0_eff   = wb0_valid && legal(wb0_rd);
  assign wb1_ready = !wb0_eff;
  assign wb1_hs    = wb1_valid && wb1_ready;
  assign wb1_eff   = wb1_hs && legal(wb1_rd);
  assign sb_eff    = sb_set && legal(sb_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb0_eff | wb1_eff;
      unique case (1'b1)
        wb0_eff: begin
          rf_rd    <= wb0_rd;
          rf_wdata <= wb0_data;
        end
        wb1_eff: begin
          rf_rd    <= wb1_rd;
          rf_wdata <= wb1_data;
        end
        default: ;
      endcase
    end
  end

  // A same-edge issue beats the retiring write: it is the newer producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb      <= '0;
      err_waw <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (sb_eff && sb_rd == RADDR_W'(i))
          sb[i] <= 1'b1;
        else if (wb1_eff && wb1_rd == RADDR_W'(i))
          sb[i] <= 1'b0;
      end
      if (wb0_eff && sb_hit(sb, wb0_rd))
        err_waw <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      cnt        <= '0;
      stall_pipe <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      stall_pipe <= stall_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall_n = 1'b0;
    unique case (state)
      NORMAL: begin
        if (wb1_valid && !wb1_ready)
          cnt_n = (cnt == LIM) ? LIM : cnt + 4'd1;
        else
          cnt_n = '0;
        if (cnt_n == LIM)
          state_n = HOLD;
      end
      HOLD: begin
        if (wb1_hs || !wb1_valid) begin
          state_n = NORMAL;
          cnt_n   = '0;
        end
        stall_n = (state_n == HOLD);
      end
      default: state_n = NORMAL;
    endcase
  end

  assign sb1  = sb_hit(sb, rs1);
  assign sb2  = sb_hit(sb, rs2);
  assign fly1 = rf_we && (rf_rd == rs1) && (rs1 != '0);
  assign fly2 = rf_we && (rf_rd == rs2) && (rs2 != '0);

`ifdef WB_ARB_FWD_EN
  assign rs1_busy      = sb1;
  assign rs2_busy      = sb2;
  assign rs1_fwd_valid = fly1;
  assign rs2_fwd_valid = fly2;
  assign rs1_fwd_data  = rf_wdata;
  assign rs2_fwd_data  = rf_wdata;
`else
  assign rs1_busy      = sb1 | fly1;
  assign rs2_busy      = sb2 | fly2;
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Expected values are hand-computed per scenario.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb0_valid, wb1_valid, wb1_ready;
  logic [5:0]  wb0_rd, wb1_rd, sb_rd, rs1, rs2, rf_rd;
  logic [63:0] wb0_data, wb1_data, rf_wdata;
  logic [63:0] rs1_fwd_data, rs2_fwd_data;
  logic        sb_set, rs1_busy, rs2_busy, stall_pipe;
  logic        rf_we, rs1_fwd_valid, rs2_fwd_valid, err_waw;

  int nvec = 0;
  int nerr = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd),
    .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready),
    .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .sb_set(sb_set), .sb_rd(sb_rd),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rs1_fwd_valid(rs1_fwd_valid),
    .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_data(rs2_fwd_data),
    .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
    sb_set = 0; sb_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic test_reset();
    sb_set = 1; sb_rd = 6'd10; tick();
    sb_rd = 6'd11; tick();
    sb_rd = 6'd12; tick();
    sb_set = 0;
    wb0_valid = 1; wb0_rd = 6'd10; wb0_data = 64'h5;
    wb1_valid = 1; wb1_rd = 6'd3;  wb1_data = 64'h6;
    repeat (6) tick();
    nvec++;
    if (stall_pipe !== 1'b1) begin
      nerr++;
      $display("FAIL pre_rst_stall got %b exp 1", stall_pipe);
    end
    nvec++;
    if (err_waw !== 1'b1) begin
      nerr++;
      $display("FAIL pre_rst_waw got %b exp 1", err_waw);
    end
    #2;
    rst_n = 0;
    idle();
    rs1 = 6'd10; rs2 = 6'd11;
    #1;
    nvec++;
    if (stall_pipe !== 1'b0) begin
      nerr++;
      $display("FAIL rst_stall got %b exp 0", stall_pipe);
    end
    nvec++;
    if (rf_we !== 1'b0) begin
      nerr++;
      $display("FAIL rst_we got %b exp 0", rf_we);
    end
    nvec++;
    if (rf_rd !== 6'd0 || rf_wdata !== 64'd0) begin
      nerr++;
      $display("FAIL rst_rd got %0h/%0h exp 0/0",
               rf_rd, rf_wdata);
    end
    nvec++;
    if (err_waw !== 1'b0) begin
      nerr++;
      $display("FAIL rst_waw got %b exp 0", err_waw);
    end
    nvec++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      nerr++;
      $display("FAIL rst_busy got %b%b exp 00",
               rs1_busy, rs2_busy);
    end
    rs1 = 6'd12;
    #1;
    nvec++;
    if (rs1_busy !== 1'b0) begin
      nerr++;
      $display("FAIL rst_busy12 got %b exp 0", rs1_busy);
    end
    rst_n = 1;
    idle();
    tick();
  endtask

  task automatic test_arb();
    wb0_valid = 1; wb0_rd = 6'd5; wb0_data = 64'h11;
    wb1_valid = 1; wb1_rd = 6'd7; wb1_data = 64'h22;
    #1;
    nvec++;
    if (wb1_ready !== 1'b0) begin
      nerr++;
      $display("FAIL arb_rdy0 got %b exp 0", wb1_ready);
    end
    tick();
    nvec++;
    if (rf_we !== 1 || rf_rd !== 6'd5 || rf_wdata !== 64'h11) begin
      nerr++;
      $display("FAIL arb_wb0 got %b/%0d/%0h exp 1/5/11",
               rf_we, rf_rd, rf_wdata);
    end
    wb0_valid = 0;
    #1;
    nvec++;
    if (wb1_ready !== 1'b1) begin
      nerr++;
      $display("FAIL arb_rdy1 got %b exp 1", wb1_ready);
    end
    tick();
    nvec++;
    if (rf_we !== 1 || rf_rd !== 6'd7 || rf_wdata !== 64'h22) begin
      nerr++;
      $display("FAIL arb_wb1 got %b/%0d/%0h exp 1/7/22",
               rf_we, rf_rd, rf_wdata);
    end
    idle();
    tick();
    nvec++;
    if (rf_we !== 0 || rf_rd !== 6'd7 || rf_wdata !== 64'h22) begin
      nerr++;
      $display("FAIL arb_hold got %b/%0d/%0h exp 0/7/22",
               rf_we, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_x0();
    wb0_valid = 1; wb0_rd = 6'd0; wb0_data = 64'hFF;
    wb1_valid = 1; wb1_rd = 6'd3; wb1_data = 64'h33;
    #1;
    nvec++;
    if (wb1_ready !== 1'b1) begin
      nerr++;
      $display("FAIL x0_rdy got %b exp 1", wb1_ready);
    end
    tick();
    nvec++;
    if (rf_we !== 1 || rf_rd !== 6'd3 || rf_wdata !== 64'h33) begin
      nerr++;
      $display("FAIL x0_wb1 got %b/%0d/%0h exp 1/3/33",
               rf_we, rf_rd, rf_wdata);
    end
    idle();
    wb0_valid = 1; wb0_rd = 6'd40; wb0_data = 64'h77;
    #1;
    nvec++;
    if (wb1_ready !== 1'b1) begin
      nerr++;
      $display("FAIL ill_rdy got %b exp 1", wb1_ready);
    end
    tick();
    nvec++;
    if (rf_we !== 1'b0) begin
      nerr++;
      $display("FAIL ill_we got %b exp 0", rf_we);
    end
    idle();
    wb1_valid = 1; wb1_rd = 6'd0; wb1_data = 64'h88;
    #1;
    nvec++;
    if (wb1_ready !== 1'b1) begin
      nerr++;
      $display("FAIL x0w1_rdy got %b exp 1", wb1_ready);
    end
    tick();
    nvec++;
    if (rf_we !== 1'b0 || rf_rd !== 6'd3) begin
      nerr++;
      $display("FAIL x0w1_we got %b/%0d exp 0/3",
               rf_we, rf_rd);
    end
    idle();
    tick();
  endtask

  task automatic test_starve();
    wb0_valid = 1; wb0_rd = 6'd6; wb0_data = 64'h1;
    wb1_valid = 1; wb1_rd = 6'd3; wb1_data = 64'h44;
    for (int i = 1; i <= 4; i++) begin
      tick();
      nvec++;
      if (stall_pipe !== 1'b0) begin
        nerr++;
        $display("FAIL starve_c%0d got %b exp 0",
                 i, stall_pipe);
      end
    end
    tick();
    nvec++;
    if (stall_pipe !== 1'b1) begin
      nerr++;
      $display("FAIL starve_c5 got %b exp 1", stall_pipe);
    end
    tick();
    nvec++;
    if (stall_pipe !== 1'b1) begin
      nerr++;
      $display("FAIL starve_c6 got %b exp 1", stall_pipe);
    end
    wb0_valid = 0;
    #1;
    nvec++;
    if (wb1_ready !== 1'b1) begin
      nerr++;
      $display("FAIL starve_rdy got %b exp 1", wb1_ready);
    end
    tick();
    nvec++;
    if (stall_pipe !== 1'b0) begin
      nerr++;
      $display("FAIL starve_fall got %b exp 0", stall_pipe);
    end
    nvec++;
    if (rf_we !== 1 || rf_rd !== 6'd3 || rf_wdata !== 64'h44) begin
      nerr++;
      $display("FAIL starve_wr got %b/%0d/%0h exp 1/3/44",
               rf_we, rf_rd, rf_wdata);
    end
    idle();
    tick();
  endtask

  task automatic test_sb();
    sb_set = 1; sb_rd = 6'd9;
    tick();
    sb_set = 0;
    rs1 = 6'd9; rs2 = 6'd8;
    #1;
    nvec++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      nerr++;
      $display("FAIL sb_set got %b%b exp 10",
               rs1_busy, rs2_busy);
    end
    sb_set = 1; sb_rd = 6'd9;
    wb1_valid = 1; wb1_rd = 6'd9; wb1_data = 64'h99;
    tick();
    sb_set = 0; wb1_valid = 0;
    tick();
    nvec++;
    if (rs1_busy !== 1'b1) begin
      nerr++;
      $display("FAIL sb_same got %b exp 1", rs1_busy);
    end
    nvec++;
    if (err_waw !== 1'b0) begin
      nerr++;
      $display("FAIL waw_pre got %b exp 0", err_waw);
    end
    wb0_valid = 1; wb0_rd = 6'd9; wb0_data = 64'h123;
    tick();
    wb0_valid = 0;
    nvec++;
    if (err_waw !== 1'b1) begin
      nerr++;
      $display("FAIL waw_set got %b exp 1", err_waw);
    end
    wb1_valid = 1; wb1_rd = 6'd9; wb1_data = 64'h9A;
    tick();
    wb1_valid = 0;
`ifdef WB_ARB_FWD_EN
    nvec++;
    if (rs1_busy !== 1'b0) begin
      nerr++;
      $display("FAIL sb_fly got %b exp 0", rs1_busy);
    end
`else
    nvec++;
    if (rs1_busy !== 1'b1) begin
      nerr++;
      $display("FAIL sb_fly got %b exp 1", rs1_busy);
    end
`endif
    tick();
    nvec++;
    if (rs1_busy !== 1'b0) begin
      nerr++;
      $display("FAIL sb_clr got %b exp 0", rs1_busy);
    end
    nvec++;
    if (err_waw !== 1'b1) begin
      nerr++;
      $display("FAIL waw_stick got %b exp 1", err_waw);
    end
    idle();
    tick();
  endtask

  task automatic test_fwd();
    wb0_valid = 1; wb0_rd = 6'd4; wb0_data = 64'hABCD;
    tick();
    wb0_valid = 0;
    rs2 = 6'd4; rs1 = 6'd0;
    #1;
`ifdef WB_ARB_FWD_EN
    nvec++;
    if (rs2_fwd_valid !== 1 || rs2_fwd_data !== 64'hABCD) begin
      nerr++;
      $display("FAIL fwd_hit got %b/%0h exp 1/abcd",
               rs2_fwd_valid, rs2_fwd_data);
    end
    nvec++;
    if (rs2_busy !== 1'b0) begin
      nerr++;
      $display("FAIL fwd_busy got %b exp 0", rs2_busy);
    end
`else
    nvec++;
    if (rs2_fwd_valid !== 0 || rs2_fwd_data !== 64'd0) begin
      nerr++;
      $display("FAIL fwd_off got %b/%0h exp 0/0",
               rs2_fwd_valid, rs2_fwd_data);
    end
    nvec++;
    if (rs2_busy !== 1'b1) begin
      nerr++;
      $display("FAIL fwd_busy got %b exp 1", rs2_busy);
    end
`endif
    nvec++;
    if (rs1_fwd_valid !== 1'b0 || rs1_busy !== 1'b0) begin
      nerr++;
      $display("FAIL fwd_x0 got %b/%b exp 0/0",
               rs1_fwd_valid, rs1_busy);
    end
    idle();
    tick();
  endtask

  initial begin
    rst_n = 0;
    idle();
    repeat (2) tick();
    rst_n = 1;
    tick();
    test_reset();
    test_arb();
    test_x0();
    test_starve();
    test_sb();
    test_fwd();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32-entry integer register file and shares it between two requesters.
  - Requester 0: in-order pipeline writeback. It is high priority and cannot be back-pressured.
  - Requester 1: long-latency unit (load miss / mul-div). It uses a valid/ready handshake.
- Keeps a busy-bit scoreboard of registers with outstanding long-latency writes so decode can stall.
- Prevents starvation of requester 1 by requesting a pipeline bubble.
- Sits between the WB stage and the register file; drives the file's write-enable, destination and write-data inputs.

Parameters:
XLEN, 64, data width
RADDR_W, 6, register address width (matches register file ports)
NREG, 32, architectural registers; addresses >= NREG are illegal
STARVE_LIMIT, 4, consecutive blocked cycles of requester 1 before a bubble is forced (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wb0_valid  in  1  pipeline writeback request
wb0_rd  in  RADDR_W  pipeline destination
wb0_data  in  XLEN  pipeline write data
wb1_valid  in  1  long-latency writeback request
wb1_ready  out  1  long-latency request accepted this cycle
wb1_rd  in  RADDR_W  long-latency destination
wb1_data  in  XLEN  long-latency write data
sb_set  in  1  decode issued a long-latency op
sb_rd  in  RADDR_W  its destination
rs1, rs2  in  RADDR_W  decode source addresses
rs1_busy, rs2_busy  out  1  source has a pending long-latency write
stall_pipe  out  1  request one upstream bubble
rf_we  out  1  register-file write enable
rf_rd  out  RADDR_W  register-file destination
rf_wdata  out  XLEN  register-file write data
rs1_fwd_valid, rs2_fwd_valid  out  1  forward hit (optional feature)
rs1_fwd_data, rs2_fwd_data  out  XLEN  forwarded data (optional feature)
err_waw  out  1  sticky: wb0 wrote a scoreboard-busy register

Behaviour:
- Async reset (rst_n low), effective immediately:
  - rf_we=0, rf_rd=0, rf_wdata=0.
  - stall_pipe=0, err_waw=0, all scoreboard bits 0.
  - Starvation counter 0; FSM in NORMAL.
  - Outstanding requests are discarded.
- Effective request: valid && rd != 0 && rd < NREG.
  - Requests to x0 or illegal addresses complete as no-ops and never drive rf_we.
  - An x0/illegal wb1 request still handshakes (wb1_ready=1 if the port is free).
- Arbitration, combinational:
  - wb1_ready = !(wb0 effective).
  - wb0 always wins. A no-op wb0 leaves the port free for wb1.
- Write-port outputs are registered, one-cycle latency:
  - A winner sampled at edge N gives rf_we/rf_rd/rf_wdata valid during cycle N+1.
  - The register file commits at edge N+2.
  - rf_we=0 when there is no effective winner; rf_rd/rf_wdata hold their last values.
- Scoreboard: one bit per register; bit 0 is never set.
  - Set on sb_set for an effective sb_rd.
  - Cleared when a wb1 write to that rd is accepted (the wb1 handshake edge).
  - Set and clear of the same rd on the same edge: bit stays set (newer issue).
  - rs1_busy/rs2_busy are combinational reads of the bits.
  - They are also 1 when the register is the rf_rd of an in-flight rf_we cycle; the register file has not committed that write yet.
- err_waw: set when an effective wb0 targets a busy register; cleared only by reset.
- Starvation FSM, two states:
  - NORMAL:
    - The counter increments each cycle wb1_valid && !wb1_ready.
    - The counter clears on a wb1 handshake or when wb1_valid=0.
    - When the counter reaches STARVE_LIMIT, go to HOLD.
  - HOLD:
    - stall_pipe=1 (registered; asserted the cycle after entry).
    - Stay in HOLD until a wb1 handshake, then go to NORMAL with the counter cleared and stall_pipe=0 the next cycle.
    - If wb1_valid drops while in HOLD, return to NORMAL.
- Counter saturates at STARVE_LIMIT.

Optional Feature:
- Macro WB_ARB_FWD_EN.
- Defined:
  - rsN_fwd_valid=1 when rf_we=1 and rf_rd==rsN and rsN!=0.
  - rsN_fwd_data=rf_wdata.
  - This covers the window before the register file commits.
  - rsN_busy then ignores the in-flight term and reflects the scoreboard only.
- Undefined:
  - Forward outputs are tied 0.
  - The in-flight term stays in rsN_busy.

Test Plan:
- Reset mid-HOLD with 3 scoreboard bits set -> immediately stall_pipe=0, rf_we=0, all busy=0, err_waw=0.
- wb0 rd=5 data=0x11 and wb1 rd=7 data=0x22 same cycle -> wb1_ready=0. Next cycle rf_we=1 rd=5 data=0x11. wb1 is granted once wb0 drops: rf_we=1 rd=7 data=0x22 one cycle after its handshake.
- wb0 rd=0 data=0xFF with wb1 rd=3 -> wb1_ready=1. Next cycle rf_rd=3; no write to x0 ever appears.
- wb0 effective every cycle, wb1_valid held, STARVE_LIMIT=4 -> stall_pipe rises 5 cycles after wb1_valid. wb0 drops, wb1 handshakes, stall_pipe falls the following cycle.
- sb_set rd=9 then rs1=9 -> rs1_busy=1.
  - wb1 rd=9 accepted while sb_set rd=9 on the same edge -> bit 9 stays 1.
  - A later wb0 rd=9 -> err_waw=1 and stays 1.
- WB_ARB_FWD_EN defined: wb0 rd=4 data=0xABCD, rs2=4 in the next cycle -> rs2_fwd_valid=1, rs2_fwd_data=0xABCD. Undefined: forward outputs are 0 and rs2_busy=1.
